// File: rtl/serializer_tx_scheduler.sv
// Round-robin scheduler that frames one requester word per grant (SOF, ID, payload)
// and drives it two bits per cycle onto the serializer's lane pair.
module serializer_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  parameter int GAP_CYC = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        lane1_o,
  output logic                        lane2_o,
  output logic                        busy_o,
  output logic [((NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ))-1:0] grant_id_o
);

  localparam int IDW     = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);
  localparam int ID_CYC  = (IDW + 1) / 2;
  localparam int DAT_CYC = WORD_W / 2;
  localparam int ID_PAD  = 2 * ID_CYC;
  localparam int MAXC    = (ID_CYC > DAT_CYC) ? ((ID_CYC > GAP_CYC) ? ID_CYC : GAP_CYC)
                                              : ((DAT_CYC > GAP_CYC) ? DAT_CYC : GAP_CYC);
  localparam int CNT_W   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ID, S_DATA, S_GAP} state_t;

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [ID_PAD-1:0]  r_id_sh, w_id_sh_n;
  logic [WORD_W-1:0]  r_word_sh, w_word_sh_n;
  logic [IDW-1:0]     r_last, r_gid, w_gid_n;
  logic               r_lane1, r_lane2, r_busy;
  logic               w_lane1_n, w_lane2_n;
  logic               w_found, w_accept;
  logic [IDW-1:0]     w_gnt_idx;
  logic [WORD_W-1:0]  w_sel_word;

  // Search starts one past the last winner so every valid requester gets a turn.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      int unsigned k;
      k = (int'(r_last) + i) % NUM_REQ;
      if (!w_found && req_valid[k]) begin
        w_found   = 1'b1;
        w_gnt_idx = IDW'(k);
      end
    end
  end

  assign w_accept   = (r_state == S_IDLE) && en && !reset && w_found;
  assign w_sel_word = req_data[w_gnt_idx*WORD_W +: WORD_W];
  assign req_ready  = w_accept ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  // State names the phase currently on the lanes; lane values for the next phase
  // are computed here so the outputs can be registered without an extra cycle.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_id_sh_n   = r_id_sh;
    w_word_sh_n = r_word_sh;
    w_gid_n     = r_gid;
    w_lane1_n   = 1'b0;
    w_lane2_n   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_n   = S_SOF;
          w_id_sh_n   = ID_PAD'(w_gnt_idx);
          w_word_sh_n = w_sel_word;
          w_gid_n     = w_gnt_idx;
          w_lane1_n   = 1'b1;
        end
      end
      S_SOF: begin
        w_state_n = S_ID;
        w_cnt_n   = '0;
        w_lane1_n = r_id_sh[0];
        w_lane2_n = r_id_sh[1];
        w_id_sh_n = r_id_sh >> 2;
      end
      S_ID: begin
        if (r_cnt == CNT_W'(ID_CYC - 1)) begin
          w_state_n   = S_DATA;
          w_cnt_n     = '0;
          w_lane1_n   = r_word_sh[0];
          w_lane2_n   = r_word_sh[1];
          w_word_sh_n = r_word_sh >> 2;
        end else begin
          w_cnt_n   = r_cnt + 1'b1;
          w_lane1_n = r_id_sh[0];
          w_lane2_n = r_id_sh[1];
          w_id_sh_n = r_id_sh >> 2;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_W'(DAT_CYC - 1)) begin
          w_cnt_n   = '0;
          w_state_n = (GAP_CYC > 0) ? S_GAP : S_IDLE;
        end else begin
          w_cnt_n     = r_cnt + 1'b1;
          w_lane1_n   = r_word_sh[0];
          w_lane2_n   = r_word_sh[1];
          w_word_sh_n = r_word_sh >> 2;
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
          w_cnt_n   = '0;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_id_sh   <= '0;
      r_word_sh <= '0;
      r_last    <= IDW'(NUM_REQ - 1);
      r_gid     <= '0;
      r_lane1   <= 1'b0;
      r_lane2   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_id_sh   <= w_id_sh_n;
      r_word_sh <= w_word_sh_n;
      r_gid     <= w_gid_n;
      r_lane1   <= w_lane1_n;
      r_lane2   <= w_lane2_n;
      r_busy    <= (w_state_n != S_IDLE);
      if (w_accept) r_last <= w_gnt_idx;
    end
  end

  assign lane1_o    = r_lane1;
  assign lane2_o    = r_lane2;
  assign busy_o     = r_busy;
  assign grant_id_o = r_gid;

endmodule

// File: tb/tb_serializer_tx_scheduler.sv
// Directed bench for serializer_tx_scheduler: default instance plus a
// NUM_REQ=2 / WORD_W=4 / GAP_CYC=0 instance sharing clock and reset.
module tb_serializer_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        lane1, lane2, busy;
  logic [1:0]  gid;

  logic        en5;
  logic [1:0]  valid5;
  logic [7:0]  data5;
  logic [1:0]  ready5;
  logic        l1_5, l2_5, busy5;
  logic [0:0]  gid5;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serializer_tx_scheduler #(.NUM_REQ(4), .WORD_W(8), .GAP_CYC(1)) u_dut (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .lane1_o(lane1), .lane2_o(lane2), .busy_o(busy),
    .grant_id_o(gid)
  );

  serializer_tx_scheduler #(.NUM_REQ(2), .WORD_W(4), .GAP_CYC(0)) u_dut5 (
    .clk(clk), .reset(reset), .en(en5), .req_valid(valid5), .req_data(data5),
    .req_ready(ready5), .lane1_o(l1_5), .lane2_o(l2_5), .busy_o(busy5),
    .grant_id_o(gid5)
  );

  typedef struct {
    logic       en;
    logic [3:0] valid;
    logic [7:0] data2;
    logic [3:0] exp_ready;
    logic       exp_l1;
    logic       exp_l2;
    logic       exp_busy;
    logic [1:0] exp_gid;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the middle of the next cycle; inputs driven afterwards hold until the next posedge.
  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    mid_cycle();
    reset = 1'b1; en = 1'b0; req_valid = '0; en5 = 1'b0; valid5 = '0;
    @(posedge clk); @(posedge clk);
    mid_cycle();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] word_of(input int g);
    return 8'h1B + 8'(g * 8'h35);
  endfunction

  vec_t vt[9];
  logic [7:0] captured;

  initial begin
    reset = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
    en5 = 1'b0; valid5 = '0; data5 = '0;
    @(posedge clk); @(posedge clk);
    mid_cycle();
    #1;
    chk("reset_outputs", {req_ready, lane1, lane2, busy, gid}, '0);
    chk("reset_outputs5", {ready5, l1_5, l2_5, busy5, gid5}, '0);
    reset = 1'b0;

    // Test 1: single frame, requester 2, payload A5.
    vt[0] = '{1, 4'b0100, 8'hA5, 4'b0100, 0, 0, 0, 2'd0};
    vt[1] = '{1, 4'b0000, 8'h00, 4'b0000, 1, 0, 1, 2'd2};
    vt[2] = '{1, 4'b0000, 8'h00, 4'b0000, 0, 1, 1, 2'd2};
    vt[3] = '{1, 4'b0000, 8'h00, 4'b0000, 1, 0, 1, 2'd2};
    vt[4] = '{1, 4'b0000, 8'h00, 4'b0000, 1, 0, 1, 2'd2};
    vt[5] = '{1, 4'b0000, 8'h00, 4'b0000, 0, 1, 1, 2'd2};
    vt[6] = '{1, 4'b0000, 8'h00, 4'b0000, 0, 1, 1, 2'd2};
    vt[7] = '{1, 4'b0000, 8'h00, 4'b0000, 0, 0, 1, 2'd2};
    vt[8] = '{1, 4'b0000, 8'h00, 4'b0000, 0, 0, 0, 2'd2};
    for (int i = 0; i < 9; i++) begin
      mid_cycle();
      en = vt[i].en; req_valid = vt[i].valid; req_data = {8'h00, vt[i].data2, 16'h0000};
      #1;
      chk($sformatf("t1_ready[%0d]", i), req_ready, vt[i].exp_ready);
      chk($sformatf("t1_lanes[%0d]", i), {lane1, lane2}, {vt[i].exp_l1, vt[i].exp_l2});
      chk($sformatf("t1_busy[%0d]", i), busy, vt[i].exp_busy);
      chk($sformatf("t1_gid[%0d]", i), gid, vt[i].exp_gid);
    end

    // Test 2: all four valid continuously -> strict rotation with period 8.
    do_reset();
    req_data = {word_of(3), word_of(2), word_of(1), word_of(0)};
    for (int c = 0; c < 40; c++) begin
      int g, ph;
      logic [7:0] w;
      logic [1:0] gb;
      if (c > 0) mid_cycle();
      en = 1'b1; req_valid = 4'b1111;
      #1;
      g = (c / 8) % 4; ph = c % 8; w = word_of(g); gb = 2'(g);
      chk($sformatf("t2_ready[%0d]", c), req_ready, (ph == 0) ? (4'b0001 << g) : 4'b0000);
      chk($sformatf("t2_busy[%0d]", c), busy, (ph != 0));
      if (ph == 1) chk($sformatf("t2_sof[%0d]", c), {lane1, lane2}, 2'b10);
      if (ph == 1) chk($sformatf("t2_gid[%0d]", c), gid, gb);
      if (ph == 2) chk($sformatf("t2_id[%0d]", c), {lane1, lane2}, {gb[0], gb[1]});
      if (ph >= 3 && ph <= 6)
        chk($sformatf("t2_data[%0d]", c), {lane1, lane2}, {w[2*(ph-3)], w[2*(ph-3)+1]});
      if (ph == 7) chk($sformatf("t2_gap[%0d]", c), {lane1, lane2}, 2'b00);
    end

    // Test 3: enable gating.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c > 0) mid_cycle();
      en = 1'b0; req_valid = 4'b1111;
      #1;
      chk($sformatf("t3_blocked[%0d]", c), {req_ready, lane1, lane2, busy}, '0);
    end
    mid_cycle();
    en = 1'b1;
    #1;
    chk("t3_grant0", req_ready, 4'b0001);

    // Test 4: reset during the second DATA cycle.
    do_reset();
    en = 1'b1; req_valid = 4'b0010; req_data = 32'h0000_3C00;
    #1;
    chk("t4_accept", req_ready, 4'b0010);
    for (int c = 1; c <= 4; c++) begin
      mid_cycle();
      req_valid = '0;
      #1;
      chk($sformatf("t4_busy[%0d]", c), busy, 1'b1);
    end
    reset = 1'b1; req_valid = 4'b1001;
    #1;
    chk("t4_ready_in_reset", req_ready, 4'b0000);
    mid_cycle();
    #1;
    chk("t4_after_reset", {lane1, lane2, busy}, 3'b000);
    reset = 1'b0; req_valid = 4'b1001;
    #1;
    chk("t4_req0_first", req_ready, 4'b0001);

    // Test 6: payload latched at acceptance only.
    do_reset();
    en = 1'b1; req_valid = 4'b0001; req_data = 32'h0000_00C3;
    #1;
    chk("t6_accept", req_ready, 4'b0001);
    captured = '0;
    for (int c = 1; c <= 6; c++) begin
      mid_cycle();
      req_valid = '0; req_data = 32'h0000_0000;
      #1;
      if (c >= 3) begin
        captured[2*(c-3)]   = lane1;
        captured[2*(c-3)+1] = lane2;
      end
    end
    chk("t6_payload", captured, 8'hC3);

    // Test 5: GAP_CYC=0, WORD_W=4, NUM_REQ=2, req 1 continuously valid with 6.
    do_reset();
    for (int c = 0; c < 15; c++) begin
      int ph;
      logic [1:0] el;
      if (c > 0) mid_cycle();
      en5 = 1'b1; valid5 = 2'b10; data5 = 8'h60;
      #1;
      ph = c % 5;
      case (ph)
        1:       el = 2'b10;
        2:       el = 2'b10;
        3:       el = 2'b01;
        4:       el = 2'b10;
        default: el = 2'b00;
      endcase
      chk($sformatf("t5_ready[%0d]", c), ready5, (ph == 0) ? 2'b10 : 2'b00);
      chk($sformatf("t5_lanes[%0d]", c), {l1_5, l2_5}, el);
      chk($sformatf("t5_busy[%0d]", c), busy5, (ph != 0));
      if (ph != 0) chk($sformatf("t5_gid[%0d]", c), gid5, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
